// File: rtl/pipeline_run_ctrl_pkg.sv
// Shared constants, command codes and state encoding for the pipeline run controller.
package pipeline_ctrl_pkg;

  localparam int NB_REG        = 32;
  localparam int NB_REG_ADDR   = 5;
  localparam int REGFILE_DEPTH = 32;
  localparam int NB_CMD        = 8;
  localparam int NB_CYCLES     = 32;
  localparam int DRAIN_CYCLES  = 4;
  localparam int NB_DRAIN      = 3;
  localparam int DUMP_WORDS    = REGFILE_DEPTH + 2;
  localparam int NB_IDX        = $clog2(DUMP_WORDS);

  localparam logic [NB_CMD-1:0] CMD_RUN        = 8'h01;
  localparam logic [NB_CMD-1:0] CMD_STEP       = 8'h02;
  localparam logic [NB_CMD-1:0] CMD_DUMP       = 8'h03;
  localparam logic [NB_CMD-1:0] CMD_RESET_PIPE = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DUMP  = 3'd4,
    ST_PRST  = 3'd5
  } state_t;

  // Cycle counter holds at all-ones instead of wrapping.
  function automatic logic [NB_CYCLES-1:0] sat_inc(input logic [NB_CYCLES-1:0] v);
    return (&v) ? v : v + NB_CYCLES'(1);
  endfunction

endpackage

// File: rtl/pipeline_run_ctrl_if.sv
// Host command, pipeline control, debug read and snapshot stream signals of the run controller.
interface pipeline_run_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic [NB_CMD-1:0]      i_cmd;
  logic                   i_cmd_valid;
  logic                   o_cmd_ready;
  logic                   i_halt;
  logic [NB_REG-1:0]      i_pc;
  logic                   o_pipe_valid;
  logic                   o_pipe_reset;
  logic [NB_REG_ADDR-1:0] o_dbg_addr;
  logic [NB_REG-1:0]      i_dbg_data;
  logic [NB_REG-1:0]      o_tx_data;
  logic                   o_tx_valid;
  logic                   i_tx_ready;
  logic [NB_CYCLES-1:0]   o_cycles;
  logic                   o_halted;
  logic [2:0]             o_state;

  modport slave (
    input  i_cmd, i_cmd_valid, i_halt, i_pc, i_dbg_data, i_tx_ready,
    output o_cmd_ready, o_pipe_valid, o_pipe_reset, o_dbg_addr, o_tx_data,
           o_tx_valid, o_cycles, o_halted, o_state
  );

  modport master (
    output i_cmd, i_cmd_valid, i_halt, i_pc, i_dbg_data, i_tx_ready,
    input  o_cmd_ready, o_pipe_valid, o_pipe_reset, o_dbg_addr, o_tx_data,
           o_tx_valid, o_cycles, o_halted, o_state
  );

endinterface

// File: rtl/pipeline_run_ctrl_dump_sequencer.sv
// Walks the register file, then PC, then cycle count out over the snapshot word stream.
module dump_sequencer
  import pipeline_ctrl_pkg::*;
(
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   en,
  input  logic                   tx_ready,
  input  logic [NB_REG-1:0]      dbg_data,
  input  logic [NB_REG-1:0]      pc,
  input  logic [NB_CYCLES-1:0]   cycles,
  output logic [NB_REG_ADDR-1:0] dbg_addr,
  output logic [NB_REG-1:0]      tx_data,
  output logic                   tx_valid,
  output logic                   done
);

  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(DUMP_WORDS - 1);

  logic [NB_IDX-1:0] idx_r;

  // Word index: advances on each accepted word, parked at zero when not dumping.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      idx_r <= NB_IDX'(0);
    end else if (!en) begin
      idx_r <= NB_IDX'(0);
    end else if (tx_ready) begin
      idx_r <= (idx_r == LAST_IDX) ? NB_IDX'(0) : idx_r + NB_IDX'(1);
    end else begin
      idx_r <= idx_r;
    end
  end

  // Word mux and handshake decode; data depends only on the index so it holds under backpressure.
  always_comb begin
    tx_data  = NB_REG'(0);
    tx_valid = en;
    done     = en & tx_ready & (idx_r == LAST_IDX);
    dbg_addr = en ? idx_r[NB_REG_ADDR-1:0] : NB_REG_ADDR'(0);
    if (idx_r < NB_IDX'(REGFILE_DEPTH)) begin
      tx_data = dbg_data;
    end else if (idx_r == NB_IDX'(REGFILE_DEPTH)) begin
      tx_data = pc;
    end else begin
      tx_data = NB_REG'(cycles);
    end
  end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run/step/drain/dump controller sitting between the host link and the five-stage pipeline.
module pipeline_run_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic          i_clock,
  input  logic          i_reset,
  pipeline_run_ctrl_if.slave bus
);

  state_t               state_r;
  state_t               state_s;
  logic [NB_DRAIN-1:0]  drain_r;
  logic [NB_CYCLES-1:0] cycles_r;
  logic                 halted_r;
  logic                 dump_en_s;
  logic                 dump_done_s;

  // State register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; commands are only taken in IDLE, RUN/STEP are refused once halted.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_cmd_valid) begin
          case (bus.i_cmd)
            CMD_RUN:        state_s = halted_r ? ST_IDLE : ST_RUN;
            CMD_STEP:       state_s = halted_r ? ST_IDLE : ST_STEP;
            CMD_DUMP:       state_s = ST_DUMP;
            CMD_RESET_PIPE: state_s = ST_PRST;
            default:        state_s = ST_IDLE;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN:   state_s = bus.i_halt ? ST_DRAIN : ST_RUN;
      ST_DRAIN: state_s = (drain_r == NB_DRAIN'(1)) ? ST_IDLE : ST_DRAIN;
      ST_STEP:  state_s = ST_IDLE;
      ST_PRST:  state_s = ST_IDLE;
      ST_DUMP:  state_s = dump_done_s ? ST_IDLE : ST_DUMP;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Cycle count, drain countdown and halt flag, all keyed off the current state.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cycles_r <= NB_CYCLES'(0);
      drain_r  <= NB_DRAIN'(0);
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          cycles_r <= sat_inc(cycles_r);
          if (bus.i_halt) begin
            drain_r <= NB_DRAIN'(DRAIN_CYCLES);
          end
        end
        ST_DRAIN: begin
          cycles_r <= sat_inc(cycles_r);
          drain_r  <= drain_r - NB_DRAIN'(1);
          if (drain_r == NB_DRAIN'(1)) begin
            halted_r <= 1'b1;
          end
        end
        ST_STEP: begin
          cycles_r <= sat_inc(cycles_r);
          if (bus.i_halt) begin
            halted_r <= 1'b1;
          end
        end
        ST_PRST: begin
          cycles_r <= NB_CYCLES'(0);
          halted_r <= 1'b0;
        end
        default: begin
          cycles_r <= cycles_r;
        end
      endcase
    end
  end

  // Output decode from the registered state.
  always_comb begin
    bus.o_cmd_ready  = (state_r == ST_IDLE);
    bus.o_pipe_valid = (state_r == ST_RUN) || (state_r == ST_DRAIN) || (state_r == ST_STEP);
    bus.o_pipe_reset = (state_r == ST_PRST);
    bus.o_cycles     = cycles_r;
    bus.o_halted     = halted_r;
    bus.o_state      = state_r;
    dump_en_s        = (state_r == ST_DUMP);
  end

  dump_sequencer u_dump (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .en       (dump_en_s),
    .tx_ready (bus.i_tx_ready),
    .dbg_data (bus.i_dbg_data),
    .pc       (bus.i_pc),
    .cycles   (cycles_r),
    .dbg_addr (bus.o_dbg_addr),
    .tx_data  (bus.o_tx_data),
    .tx_valid (bus.o_tx_valid),
    .done     (dump_done_s)
  );

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed plus randomized bench for pipeline_run_ctrl against a cycle-count/halt reference model.
module tb_pipeline_run_ctrl;
  import pipeline_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_run_ctrl_if bus();
  pipeline_run_ctrl dut (.i_clock(clk), .i_reset(rst_n), .bus(bus));

  logic [31:0] regmodel [32];
  assign bus.i_dbg_data = regmodel[bus.o_dbg_addr];

  int     checks = 0;
  int     errors = 0;
  int     pv_total = 0;
  int     pr_total = 0;
  longint m_cycles = 0;
  bit     m_halted = 1'b0;

  // Independent tallies of advance and reset pulses seen on the pipeline side.
  always @(posedge clk) begin
    if (bus.o_pipe_valid) pv_total <= pv_total + 1;
    if (bus.o_pipe_reset) pr_total <= pr_total + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat_add(input longint a, input longint b);
    longint r;
    r = a + b;
    return (r > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : r;
  endfunction

  task automatic send_cmd(input logic [7:0] c);
    @(negedge clk);
    chk("cmd_ready_idle", bus.o_cmd_ready, 1);
    bus.i_cmd = c;
    bus.i_cmd_valid = 1'b1;
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd = 8'h00;
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    while (bus.o_state !== ST_IDLE && g < 64) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_timeout"}, (g < 64), 1);
  endtask

  // Advance-count and halt check after a RUN whose n-th cycle saw i_halt.
  task automatic halt_tail(input int n, input int t0, input string tag);
    bus.i_halt = 1'b1;
    @(negedge clk);
    bus.i_halt = 1'b0;
    wait_idle(tag);
    chk({tag, "_advances"}, pv_total - t0, n + DRAIN_CYCLES);
    m_cycles = sat_add(m_cycles, n + DRAIN_CYCLES);
    m_halted = 1'b1;
    chk({tag, "_cycles"}, bus.o_cycles, m_cycles);
    chk({tag, "_halted"}, bus.o_halted, 1);
  endtask

  task automatic run_halt(input int n);
    int t0 = pv_total;
    send_cmd(CMD_RUN);
    if (m_halted) begin
      chk("run_blocked_state", bus.o_state, ST_IDLE);
      repeat (3) @(negedge clk);
      chk("run_blocked_advances", pv_total - t0, 0);
      return;
    end
    repeat (n - 1) @(negedge clk);
    chk("run_state", bus.o_state, ST_RUN);
    halt_tail(n, t0, "run");
  endtask

  task automatic step(input bit h);
    int t0 = pv_total;
    send_cmd(CMD_STEP);
    if (m_halted) begin
      chk("step_blocked_state", bus.o_state, ST_IDLE);
      @(negedge clk);
      chk("step_blocked_advances", pv_total - t0, 0);
      return;
    end
    chk("step_state", bus.o_state, ST_STEP);
    chk("step_pipe_valid", bus.o_pipe_valid, 1);
    chk("step_cmd_ready", bus.o_cmd_ready, 0);
    bus.i_halt = h;
    @(negedge clk);
    bus.i_halt = 1'b0;
    chk("step_back_idle", bus.o_state, ST_IDLE);
    chk("step_advances", pv_total - t0, 1);
    m_cycles = sat_add(m_cycles, 1);
    if (h) m_halted = 1'b1;
    chk("step_cycles", bus.o_cycles, m_cycles);
    chk("step_halted", bus.o_halted, m_halted);
  endtask

  task automatic dump(input bit random_ready);
    logic [31:0] exp_w [DUMP_WORDS];
    int k = 0;
    int g = 0;
    bit phase = 1'b1;
    bit rdy;
    for (int i = 0; i < REGFILE_DEPTH; i++) exp_w[i] = regmodel[i];
    exp_w[REGFILE_DEPTH]     = bus.i_pc;
    exp_w[REGFILE_DEPTH + 1] = m_cycles[31:0];
    send_cmd(CMD_DUMP);
    while (k < DUMP_WORDS && g < 400) begin
      @(negedge clk);
      chk("dump_tx_valid", bus.o_tx_valid, 1);
      chk($sformatf("dump_word%0d", k), bus.o_tx_data, exp_w[k]);
      chk("dump_pipe_frozen", bus.o_pipe_valid, 0);
      rdy = random_ready ? 1'($urandom_range(0, 1)) : phase;
      phase = ~phase;
      bus.i_tx_ready = rdy;
      if (rdy) k++;
      g++;
    end
    chk("dump_word_count", k, DUMP_WORDS);
    @(negedge clk);
    bus.i_tx_ready = 1'b0;
    chk("dump_end_state", bus.o_state, ST_IDLE);
    chk("dump_end_tx_valid", bus.o_tx_valid, 0);
    chk("dump_end_dbg_addr", bus.o_dbg_addr, 0);
  endtask

  task automatic reset_pipe();
    int t0 = pr_total;
    send_cmd(CMD_RESET_PIPE);
    chk("prst_pulse", bus.o_pipe_reset, 1);
    chk("prst_no_advance", bus.o_pipe_valid, 0);
    @(negedge clk);
    chk("prst_state", bus.o_state, ST_IDLE);
    chk("prst_pulse_count", pr_total - t0, 1);
    m_cycles = 0;
    m_halted = 1'b0;
    chk("prst_cycles", bus.o_cycles, 0);
    chk("prst_halted", bus.o_halted, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int t0;
    bus.i_cmd = 8'h00;
    bus.i_cmd_valid = 1'b0;
    bus.i_halt = 1'b0;
    bus.i_pc = 32'h0000_0040;
    bus.i_tx_ready = 1'b0;
    for (int i = 0; i < 32; i++) regmodel[i] = 32'(i * 4);

    repeat (2) @(negedge clk);
    chk("rst_state", bus.o_state, ST_IDLE);
    chk("rst_cycles", bus.o_cycles, 0);
    chk("rst_halted", bus.o_halted, 0);
    chk("rst_pipe_valid", bus.o_pipe_valid, 0);
    chk("rst_pipe_reset", bus.o_pipe_reset, 0);
    chk("rst_tx_valid", bus.o_tx_valid, 0);
    chk("rst_cmd_ready", bus.o_cmd_ready, 1);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a RUN.
    send_cmd(CMD_RUN);
    repeat (57) @(negedge clk);
    chk("midrun_cycles", bus.o_cycles, 57);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_rst_pipe_valid", bus.o_pipe_valid, 0);
    chk("midrun_rst_cycles", bus.o_cycles, 0);
    chk("midrun_rst_state", bus.o_state, ST_IDLE);
    chk("midrun_rst_cmd_ready", bus.o_cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    m_cycles = 0;

    for (int i = 0; i < 3; i++) step(1'b0);
    chk("three_steps_cycles", bus.o_cycles, 3);

    reset_pipe();
    run_halt(10);
    chk("run10_cycles", bus.o_cycles, 14);
    run_halt(5);

    dump(1'b0);

    reset_pipe();
    run_halt(int'($urandom_range(1, 20)));

    // Unknown code is swallowed; a held RUN is taken exactly once.
    reset_pipe();
    @(negedge clk);
    bus.i_cmd = 8'h7F;
    bus.i_cmd_valid = 1'b1;
    @(negedge clk);
    chk("junk_state", bus.o_state, ST_IDLE);
    chk("junk_cycles", bus.o_cycles, m_cycles);
    t0 = pv_total;
    bus.i_cmd = CMD_RUN;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("held_run_state", bus.o_state, ST_RUN);
      chk("held_run_cmd_ready", bus.o_cmd_ready, 0);
    end
    bus.i_cmd_valid = 1'b0;
    halt_tail(6, t0, "held_run");

    // Saturation from a preloaded counter.
    reset_pipe();
    @(negedge clk);
    force dut.cycles_r = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.cycles_r;
    @(negedge clk);
    chk("preload_cycles", bus.o_cycles, 64'hFFFF_FFFE);
    m_cycles = 64'hFFFF_FFFE;
    t0 = pv_total;
    send_cmd(CMD_RUN);
    repeat (2) @(negedge clk);
    chk("sat_cycles", bus.o_cycles, 64'hFFFF_FFFF);
    halt_tail(3, t0, "sat_run");

    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 4))
        0: step($urandom_range(0, 3) == 0);
        1: run_halt(int'($urandom_range(1, 12)));
        2: begin
          for (int i = 0; i < 32; i++) regmodel[i] = $urandom;
          bus.i_pc = $urandom;
          dump(1'b1);
        end
        3: reset_pipe();
        default: begin
          send_cmd(8'($urandom_range(5, 255)));
          chk("rand_junk_state", bus.o_state, ST_IDLE);
          chk("rand_junk_cycles", bus.o_cycles, m_cycles);
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
